router_fifo: RTL and testbench
==============================

// Module: router_fifo
// PURPOSE
//   Per-destination output FIFO of the 1x3 router; three instances sit directly downstream
//   of the register stage. Stores header, payload and parity bytes plus a 1-bit header tag.
//   Tracks remaining packet length on the read side so the full packet drains to its port.
// PARAMETERS
//   DEPTH   16  entries; power of 2, >= 4
//   DWIDTH  8   data byte width; the stored word is DWIDTH+1 bits ({hdr_tag, byte})
// PORTS
//   clk         in   1       rising-edge clock
//   resetn      in   1       asynchronous active-low reset
//   soft_reset  in   1       sync flush: destination timeout from the FSM/synchroniser
//   write_enb   in   1       write request from the synchroniser
//   read_enb    in   1       read request from the destination port
//   lfd_state   in   1       current write byte is the header; stored as hdr_tag
//   data_in     in   DWIDTH  byte from the register stage
//   full        out  1       DEPTH entries held
//   empty       out  1       0 entries held
//   data_out    out  DWIDTH  registered read data
//   dout_valid  out  1       data_out was updated by a read in the previous cycle
// BEHAVIOUR
//   - Reset (resetn=0, async): wr_ptr=rd_ptr=0, count=0, pkt_cnt=0, data_out=0, dout_valid=0,
//     empty=1, full=0, memory contents don't-care.
//   - soft_reset=1 at a clock edge has the same effect as reset and overrides write_enb/read_enb that cycle.
//   - Pointers are $clog2(DEPTH)+1 bits. empty = (wr_ptr==rd_ptr).
//     full = address bits equal and MSBs differ. Both are combinational from registered pointers.
//   - Write accepted iff write_enb && (!full || read accepted same cycle).
//     Stores {lfd_state, data_in} at wr_ptr; wr_ptr++ wraps modulo 2*DEPTH.
//   - Read accepted iff read_enb && !empty. data_out <= mem[rd_ptr][DWIDTH-1:0] and rd_ptr++
//     on the same edge, so data_out is visible one cycle after read_enb (latency 1).
//     dout_valid=1 on the following cycle only.
//   - Read on empty: ignored, data_out holds, dout_valid=0. Write on full without a
//     simultaneous read: dropped, no state change.
//   - Simultaneous read+write: at full, both are accepted and full stays 1.
//     At empty, only the write is accepted.
//   - pkt_cnt (6 bits): on an accepted read of a word with hdr_tag=1,
//     pkt_cnt <= byte[7:2] + 1 (payload length + parity byte).
//     On an accepted read of a word with hdr_tag=0 and pkt_cnt>0, pkt_cnt decrements.
//     pkt_cnt never wraps below 0. pkt_cnt is observable only internally and by assertion.
//   - Length 0 header: pkt_cnt=1, and the parity byte read returns it to 0.
// CONFIGURATION
//   `ROUTER_FIFO_STATS_EN defined: adds ports
//     drop_cnt  out  8  saturating (at 255) count of dropped writes
//     underrun  out  1  sticky flag, set on read_enb while empty
//   Both are cleared by resetn or soft_reset.
//   Macro undefined: these ports and their logic are absent; all other behaviour is identical.
// STRUCTURE
//   router_pkg: ROUTER_DWIDTH=8, HDR_LEN_MSB=7, HDR_LEN_LSB=2, HDR_ADDR_W=2,
//     typedef fifo_word_t {logic hdr; logic [7:0] data;}.
//   Sub-module router_fifo_mem: DEPTH x (DWIDTH+1) storage array, one write port,
//     one async read port, no reset.
//   Pointer/flag/length logic stays in router_fifo.
// TESTING
//   1 Reset mid-traffic: 5 writes, resetn low for 1 cycle -> empty=1, full=0,
//     data_out=0, dout_valid=0 (without waiting for a clock edge).
//   2 Header 8'h0E then 3 payload bytes + parity 8'hA5, drain -> data_out sequence
//     0E,..,A5, dout_valid for 5 cycles, pkt_cnt 4,3,2,1,0.
//   3 Fill 16 writes -> full=1. 17th write 8'h55 dropped. Drain -> 16 bytes in order,
//     no 8'h55, empty=1.
//   4 At full, assert read_enb and write_enb with 8'h77 -> full stays 1.
//     8'h77 is read out last after 15 reads.
//   5 Empty FIFO with read_enb+write_enb 8'h33 -> dout_valid=0 that cycle.
//     Next read returns 33.
//   6 soft_reset while 6 entries held -> empty=1 next cycle, pointers 0.
//     With STATS_EN: drop_cnt=0.
//     Separate case: 3 dropped writes -> drop_cnt=3.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and header-field constants for the 1x3 router datapath.
package router_pkg;

  localparam int unsigned ROUTER_DWIDTH = 8;
  localparam int unsigned HDR_LEN_MSB   = 7;
  localparam int unsigned HDR_LEN_LSB   = 2;
  localparam int unsigned HDR_ADDR_W    = 2;
  localparam int unsigned PKT_CNT_W     = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  // One FIFO entry: header tag plus the byte as it arrived.
  typedef struct packed {
    logic                     hdr;
    logic [ROUTER_DWIDTH-1:0] data;
  } fifo_word_t;

  // Bytes still to drain after the header: payload length plus the parity byte.
  function automatic logic [PKT_CNT_W-1:0] hdr_pkt_len(input logic [PKT_CNT_W-1:0] len);
    return PKT_CNT_W'(len + PKT_CNT_W'(1));
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Storage array for router_fifo: one synchronous write port, one asynchronous
// read port, no reset (contents are don't-care after reset).
//   clk    in  clock
//   we     in  write strobe
//   waddr  in  write address
//   wdata  in  write word
//   raddr  in  read address
//   rdata  out read word (combinational)
module router_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x3 router. Stores {hdr_tag, byte} and
// tracks the remaining packet length on the read side.
//   clk, resetn      clock, async active-low reset
//   soft_reset       synchronous flush (destination timeout)
//   write_enb        write request; lfd_state tags the byte as a header
//   data_in          byte from the register stage
//   read_enb         read request from the destination port
//   full, empty      occupancy flags, combinational from registered pointers
//   data_out         registered read data, updated one cycle after an accepted read
//   dout_valid       high the cycle after an accepted read
// Optional: `ROUTER_FIFO_STATS_EN adds drop_cnt (saturating dropped-write count)
// and underrun (sticky read-while-empty flag).
module router_fifo
  import router_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DWIDTH = ROUTER_DWIDTH
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DWIDTH-1:0] data_in,
  output logic              full,
  output logic              empty,
  output logic [DWIDTH-1:0] data_out,
  output logic              dout_valid
`ifdef ROUTER_FIFO_STATS_EN
  ,
  output logic [7:0]        drop_cnt,
  output logic              underrun
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Elaboration-time guards on the parameter space this block supports.
  if (DWIDTH != ROUTER_DWIDTH) begin : g_bad_dwidth
    $error("router_fifo: DWIDTH must equal ROUTER_DWIDTH");
  end
  if ((DEPTH < 4) || ((1 << AW) != DEPTH)) begin : g_bad_depth
    $error("router_fifo: DEPTH must be a power of 2 and >= 4");
  end
  if (HDR_LEN_LSB != HDR_ADDR_W) begin : g_bad_hdr
    $error("router_fifo: header length field must sit directly above the address field");
  end

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [DWIDTH-1:0]    data_out_q, data_out_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 rd_acc_c, wr_acc_c;
  fifo_word_t           wr_word, rd_word;

  // Flags from registered pointers; the extra MSB distinguishes full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // A read at full frees a slot, so a simultaneous write is still accepted.
  assign rd_acc_c = read_enb && !empty;
  assign wr_acc_c = write_enb && (!full || rd_acc_c);

  assign wr_word.hdr  = lfd_state;
  assign wr_word.data = ROUTER_DWIDTH'(data_in);

  router_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fifo_word_t))
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc_c && !soft_reset),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wr_word),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_word)
  );

  // Next-state for pointers, read data and remaining packet length.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pkt_cnt_d    = pkt_cnt_q;
    data_out_d   = data_out_q;
    dout_valid_d = rd_acc_c;
    if (wr_acc_c) wr_ptr_d = PW'(wr_ptr_q + PW'(1));
    if (rd_acc_c) begin
      rd_ptr_d   = PW'(rd_ptr_q + PW'(1));
      data_out_d = DWIDTH'(rd_word.data);
      if (rd_word.hdr) begin
        pkt_cnt_d = hdr_pkt_len(rd_word.data[HDR_LEN_MSB:HDR_LEN_LSB]);
      end else if (pkt_cnt_q != '0) begin
        pkt_cnt_d = PKT_CNT_W'(pkt_cnt_q - PKT_CNT_W'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pkt_cnt_q    <= '0;
      data_out_q   <= '0;
      dout_valid_q <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pkt_cnt_q    <= '0;
      data_out_q   <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_cnt_q    <= pkt_cnt_d;
      data_out_q   <= data_out_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign dout_valid = dout_valid_q;

`ifdef ROUTER_FIFO_STATS_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic       underrun_q, underrun_d;

  // Dropped-write counter saturates; underrun is sticky until a reset.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    underrun_d = underrun_q | (read_enb && empty);
    if (write_enb && !wr_acc_c && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = 8'(drop_cnt_q + 8'd1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_cnt_q <= '0;
      underrun_q <= 1'b0;
    end else if (soft_reset) begin
      drop_cnt_q <= '0;
      underrun_q <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      underrun_q <= underrun_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign underrun = underrun_q;
`endif

`ifndef SYNTHESIS
  // Remaining length saturates at zero on untagged reads.
  a_pkt_no_wrap: assert property (@(posedge clk) disable iff (!resetn)
    (rd_acc_c && !rd_word.hdr && (pkt_cnt_q == '0) && !soft_reset) |=> (pkt_cnt_q == '0));
`endif

endmodule

// File: tb/tb_router_fifo.sv
module tb_router_fifo;

  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       resetn, soft_reset, write_enb, read_enb, lfd_state;
  logic [7:0] data_in;
  logic       full, empty, dout_valid;
  logic [7:0] data_out;
`ifdef ROUTER_FIFO_STATS_EN
  logic [7:0] drop_cnt;
  logic       underrun;
`endif

  router_fifo #(.DEPTH(DEPTH), .DWIDTH(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .full       (full),
    .empty      (empty),
    .data_out   (data_out),
    .dout_valid (dout_valid)
`ifdef ROUTER_FIFO_STATS_EN
    ,
    .drop_cnt   (drop_cnt),
    .underrun   (underrun)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: a queue of {hdr, byte} entries plus the visible registers.
  logic [8:0] mq[$];
  int         m_pkt;
  logic [7:0] m_dout;
  bit         m_valid;
  int         m_drop;
  bit         m_under;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_pkt = 0; m_dout = 8'h00; m_valid = 1'b0; m_drop = 0; m_under = 1'b0;
  endtask

  task automatic check_model();
    chk("full",       32'(full),       32'(mq.size() == DEPTH));
    chk("empty",      32'(empty),      32'(mq.size() == 0));
    chk("data_out",   32'(data_out),   32'(m_dout));
    chk("dout_valid", 32'(dout_valid), 32'(m_valid));
    chk("pkt_cnt",    32'(dut.pkt_cnt_q), 32'(m_pkt));
`ifdef ROUTER_FIFO_STATS_EN
    chk("drop_cnt",   32'(drop_cnt),   32'(m_drop));
    chk("underrun",   32'(underrun),   32'(m_under));
`endif
  endtask

  // Drive one cycle, advance the model by the same rules, then compare after the edge.
  task automatic cycle(input bit sr, input bit we, input bit re, input bit lfd, input logic [7:0] din);
    int  sz;
    bit  rd, wr;
    logic [8:0] w;
    soft_reset = sr; write_enb = we; read_enb = re; lfd_state = lfd; data_in = din;
    sz = mq.size();
    if (sr) begin
      model_clear();
    end else begin
      rd = re && (sz > 0);
      wr = we && ((sz < DEPTH) || rd);
      if (we && !wr && m_drop < 255) m_drop++;
      if (re && sz == 0) m_under = 1'b1;
      m_valid = rd;
      if (rd) begin
        w = mq.pop_front();
        m_dout = w[7:0];
        if (w[8]) m_pkt = ((int'(w[7:0]) >> 2) + 1) % 64;
        else if (m_pkt > 0) m_pkt--;
      end
      if (wr) mq.push_back({lfd, din});
    end
    @(posedge clk);
    #1;
    check_model();
    soft_reset = 0; write_enb = 0; read_enb = 0; lfd_state = 0;
  endtask

  typedef struct {
    bit         we, re, lfd;
    logic [7:0] din;
    bit         e_full, e_empty;
    logic [7:0] e_dout;
    bit         e_valid;
    int         e_pkt;
  } vec_t;

  vec_t tbl[11];

  initial begin
    resetn = 1'b0; soft_reset = 0; write_enb = 0; read_enb = 0; lfd_state = 0; data_in = 8'h00;
    model_clear();
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_dout",  32'(data_out), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Header 0E (length 3), three payload bytes, parity A5, then drain.
    tbl[0]  = '{1, 0, 1, 8'h0E, 0, 0, 8'h00, 0, 0};
    tbl[1]  = '{1, 0, 0, 8'h11, 0, 0, 8'h00, 0, 0};
    tbl[2]  = '{1, 0, 0, 8'h22, 0, 0, 8'h00, 0, 0};
    tbl[3]  = '{1, 0, 0, 8'h33, 0, 0, 8'h00, 0, 0};
    tbl[4]  = '{1, 0, 0, 8'hA5, 0, 0, 8'h00, 0, 0};
    tbl[5]  = '{0, 1, 0, 8'h00, 0, 0, 8'h0E, 1, 4};
    tbl[6]  = '{0, 1, 0, 8'h00, 0, 0, 8'h11, 1, 3};
    tbl[7]  = '{0, 1, 0, 8'h00, 0, 0, 8'h22, 1, 2};
    tbl[8]  = '{0, 1, 0, 8'h00, 0, 0, 8'h33, 1, 1};
    tbl[9]  = '{0, 1, 0, 8'h00, 0, 1, 8'hA5, 1, 0};
    tbl[10] = '{0, 0, 0, 8'h00, 0, 1, 8'hA5, 0, 0};
    for (int i = 0; i < 11; i++) begin
      cycle(0, tbl[i].we, tbl[i].re, tbl[i].lfd, tbl[i].din);
      chk("tbl_full",  32'(full),       32'(tbl[i].e_full));
      chk("tbl_empty", 32'(empty),      32'(tbl[i].e_empty));
      chk("tbl_dout",  32'(data_out),   32'(tbl[i].e_dout));
      chk("tbl_valid", 32'(dout_valid), 32'(tbl[i].e_valid));
      chk("tbl_pkt",   32'(dut.pkt_cnt_q), 32'(tbl[i].e_pkt));
    end

    // Asynchronous reset mid-traffic, observed before any clock edge.
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 8'(8'h40 + i));
    cycle(0, 0, 1, 0, 8'h00);
    resetn = 1'b0;
    #2;
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full",  32'(full),  32'd0);
    chk("arst_dout",  32'(data_out), 32'd0);
    chk("arst_valid", 32'(dout_valid), 32'd0);
    model_clear();
    @(posedge clk);
    #1 resetn = 1'b1;

    // Fill to full, drop a 17th write, drain in order.
    for (int i = 0; i < 16; i++) cycle(0, 1, 0, 0, 8'(8'hA0 + i));
    chk("fill_full", 32'(full), 32'd1);
    cycle(0, 1, 0, 0, 8'h55);
    chk("drop_full", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 1, 0, 8'h00);
      chk("drain_byte", 32'(data_out), 32'(8'hA0 + i));
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Simultaneous read and write at full.
    for (int i = 0; i < 16; i++) cycle(0, 1, 0, 0, 8'(8'h10 + i));
    cycle(0, 1, 1, 0, 8'h77);
    chk("rw_full_stays", 32'(full), 32'd1);
    chk("rw_full_dout",  32'(data_out), 32'h10);
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, 0, 8'h00);
    chk("rw_full_last", 32'(data_out), 32'h77);
    chk("rw_full_empty", 32'(empty), 32'd1);

    // Simultaneous read and write at empty: only the write lands.
    cycle(0, 1, 1, 0, 8'h33);
    chk("rw_empty_valid", 32'(dout_valid), 32'd0);
    chk("rw_empty_notempty", 32'(empty), 32'd0);
    cycle(0, 0, 1, 0, 8'h00);
    chk("rw_empty_read", 32'(data_out), 32'h33);

    // Soft reset flushes held entries.
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, 8'(8'hC0 + i));
    cycle(1, 0, 0, 0, 8'h00);
    chk("sr_empty",  32'(empty), 32'd1);
    chk("sr_wr_ptr", 32'(dut.wr_ptr_q), 32'd0);
    chk("sr_rd_ptr", 32'(dut.rd_ptr_q), 32'd0);
`ifdef ROUTER_FIFO_STATS_EN
    chk("sr_drop", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 19; i++) cycle(0, 1, 0, 0, 8'(i));
    chk("drop3", 32'(drop_cnt), 32'd3);
    cycle(1, 0, 0, 0, 8'h00);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 9) < 5), ($urandom_range(0, 4) == 0),
            8'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
